// File: rtl/ahb_arb_pkg.sv
// Shared types and constants for the round-robin AHB bus arbiter.
// Holds the FSM state encoding, the htrans codes and a transfer-type helper.
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    PARK   = 2'd0,
    OWN    = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // A beat counts toward the hold limit only when it actually moves data.
  function automatic logic is_active(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_bus_arbiter_if.sv
// Request/grant bundle between the bus masters and the arbiter.
// The master modport is the arbiter side; the slave modport is the requester side.
interface ahb_bus_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  localparam int IW = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] hbusreq;
  logic [NUM_MASTERS-1:0] hlock;
  logic                   hready;
  logic [1:0]             htrans;
  logic [NUM_MASTERS-1:0] hgrant;
  logic [IW-1:0]          hmaster;
  logic                   hmastlock;

  modport master (
    input  hbusreq, hlock, hready, htrans,
    output hgrant, hmaster, hmastlock
  );

  modport slave (
    output hbusreq, hlock, hready, htrans,
    input  hgrant, hmaster, hmastlock
  );
endinterface

// File: rtl/ahb_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after start_idx,
// wrapping modulo NUM_MASTERS.
module rr_pick #(
  parameter int NUM_MASTERS = 4,
  parameter int IW          = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IW-1:0]          start_idx,
  output logic [NUM_MASTERS-1:0] grant_oh,
  output logic [IW-1:0]          grant_idx,
  output logic                   valid
);

  int            idx;
  logic [IW-1:0] idx_w;

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    valid     = 1'b0;
    idx       = 0;
    idx_w     = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx   = (int'(start_idx) + i) % NUM_MASTERS;
      idx_w = IW'(idx);
      if (!valid && req[idx_w]) begin
        valid            = 1'b1;
        grant_idx        = idx_w;
        grant_oh[idx_w]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB bus arbiter with locked-sequence support, hold limit and
// parking on a default master. All outputs are registered.
module ahb_bus_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_HOLD       = 16
) (
  input  logic                hclk,
  input  logic                hreset,
  ahb_bus_arbiter_if.master   bus
);

  localparam int                     IW       = $clog2(NUM_MASTERS);
  localparam int                     HW       = $clog2(MAX_HOLD);
  localparam logic [IW-1:0]          DEF_IDX  = IW'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_OH   = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [HW-1:0]          HOLD_MAX = HW'(MAX_HOLD - 1);
  localparam logic [IW-1:0]          LAST_IDX = IW'(NUM_MASTERS - 1);

  arb_state_t             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          owner_q, owner_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
  logic [IW-1:0]          hmaster_q, hmaster_d;
  logic                   hmastlock_q, hmastlock_d;

  logic [IW-1:0]          search_start;
  logic [NUM_MASTERS-1:0] pick_oh;
  logic [IW-1:0]          pick_idx;
  logic                   pick_valid;
  logic                   others_pending;
  logic                   rearb;

  // rr_ptr always equals the current owner, so one picker serves both the
  // parked search and the handover search.
  assign search_start = (rr_ptr_q == LAST_IDX) ? '0 : rr_ptr_q + IW'(1);

  rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .IW          (IW)
  ) u_rr_pick (
    .req       (bus.hbusreq),
    .start_idx (search_start),
    .grant_oh  (pick_oh),
    .grant_idx (pick_idx),
    .valid     (pick_valid)
  );

  assign others_pending = |(bus.hbusreq & ~grant_q);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    hold_cnt_d  = hold_cnt_q;
    hmaster_d   = hmaster_q;
    hmastlock_d = hmastlock_q;
    rearb       = 1'b0;

    if (bus.hready) begin
      hmaster_d   = owner_q;
      hmastlock_d = (state_q == LOCKED);

      unique case (state_q)
        PARK:   rearb = pick_valid && (bus.hbusreq != DEF_OH);
        OWN: begin
          if (bus.hlock[owner_q]) begin
            state_d = LOCKED;
          end else begin
            rearb = !bus.hbusreq[owner_q] ||
                    (others_pending && (hold_cnt_q == HOLD_MAX));
          end
        end
        LOCKED: rearb = !bus.hlock[owner_q] && (bus.htrans == HTRANS_IDLE);
        default: state_d = PARK;
      endcase

      if (rearb) begin
        hold_cnt_d = '0;
        if (pick_valid) begin
          grant_d  = pick_oh;
          owner_d  = pick_idx;
          rr_ptr_d = pick_idx;
          state_d  = bus.hlock[pick_idx] ? LOCKED : OWN;
        end else begin
          grant_d  = DEF_OH;
          owner_d  = DEF_IDX;
          rr_ptr_d = DEF_IDX;
          state_d  = PARK;
        end
      end else if (state_d == PARK) begin
        hold_cnt_d = '0;
      end else if (is_active(bus.htrans) && (hold_cnt_q != HOLD_MAX)) begin
        hold_cnt_d = hold_cnt_q + HW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q     <= PARK;
      grant_q     <= DEF_OH;
      owner_q     <= DEF_IDX;
      rr_ptr_q    <= DEF_IDX;
      hold_cnt_q  <= '0;
      hmaster_q   <= DEF_IDX;
      hmastlock_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      hmaster_q   <= hmaster_d;
      hmastlock_q <= hmastlock_d;
    end
  end

  assign bus.hgrant    = grant_q;
  assign bus.hmaster   = hmaster_q;
  assign bus.hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Scoreboard bench for ahb_bus_arbiter: a behavioural model queues the
// expected outputs for every edge and the sampled DUT outputs are compared.
module tb_ahb_bus_arbiter;
  import ahb_arb_pkg::*;

  localparam int N = 4;

  typedef struct {
    logic [3:0] grant;
    logic [1:0] master;
    logic       lock;
  } exp_t;

  logic hclk;
  logic hreset;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  // Model state
  arb_state_t m_state;
  int         m_owner;
  int         m_rr;
  int         m_hold;
  int         m_hmaster;
  bit         m_lock;

  ahb_bus_arbiter_if #(.NUM_MASTERS(N)) bus ();

  ahb_bus_arbiter #(
    .NUM_MASTERS    (N),
    .DEFAULT_MASTER (0),
    .MAX_HOLD       (16)
  ) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state   = PARK;
    m_owner   = 0;
    m_rr      = 0;
    m_hold    = 0;
    m_hmaster = 0;
    m_lock    = 1'b0;
  endtask

  function automatic int next_requester(input logic [3:0] req, input int from);
    for (int k = 1; k <= N; k++) begin
      if (req[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic [3:0] req, input logic [3:0] lock,
                            input logic rdy, input logic [1:0] tr);
    int         win;
    bit         arb;
    logic [3:0] own_oh;
    if (!rdy) return;
    m_hmaster = m_owner;
    m_lock    = (m_state == LOCKED);
    own_oh    = 4'b0001 << m_owner;
    arb       = 1'b0;
    case (m_state)
      PARK:   arb = (req != 4'b0000) && (req != 4'b0001);
      OWN: begin
        if (lock[m_owner]) m_state = LOCKED;
        else arb = !req[m_owner] || (((req & ~own_oh) != 4'b0000) && (m_hold == 15));
      end
      default: arb = !lock[m_owner] && (tr == HTRANS_IDLE);
    endcase
    if (arb) begin
      m_hold = 0;
      win    = next_requester(req, m_rr);
      if (win < 0) begin
        m_owner = 0;
        m_rr    = 0;
        m_state = PARK;
      end else begin
        m_owner = win;
        m_rr    = win;
        m_state = lock[win] ? LOCKED : OWN;
      end
    end else if (m_state == PARK) begin
      m_hold = 0;
    end else if ((tr == HTRANS_NONSEQ || tr == HTRANS_SEQ) && m_hold < 15) begin
      m_hold++;
    end
  endtask

  // One clock: drive, queue expectation, let the edge happen, compare #1 later.
  task automatic cycle(input logic [3:0] req, input logic [3:0] lock,
                       input logic rdy, input logic [1:0] tr);
    exp_t e;
    bus.hbusreq = req;
    bus.hlock   = lock;
    bus.hready  = rdy;
    bus.htrans  = tr;
    model_edge(req, lock, rdy, tr);
    e.grant  = 4'b0001 << m_owner;
    e.master = 2'(m_hmaster);
    e.lock   = m_lock;
    sb_q.push_back(e);
    @(posedge hclk);
    #1;
    e = sb_q.pop_front();
    check("hgrant", 32'(bus.hgrant), 32'(e.grant));
    check("hmaster", 32'(bus.hmaster), 32'(e.master));
    check("hmastlock", 32'(bus.hmastlock), 32'(e.lock));
  endtask

  initial begin
    logic [3:0] rq;
    logic [3:0] lk;
    logic       rd;
    logic [1:0] tr;

    hreset      = 1'b1;
    bus.hbusreq = '0;
    bus.hlock   = '0;
    bus.hready  = 1'b1;
    bus.htrans  = HTRANS_IDLE;
    model_reset();
    #12;
    check("rst_hgrant", 32'(bus.hgrant), 32'h1);
    check("rst_hmaster", 32'(bus.hmaster), 32'h0);
    check("rst_hmastlock", 32'(bus.hmastlock), 32'h0);
    hreset = 1'b0;

    repeat (3) cycle(4'b0000, 4'b0000, 1'b1, HTRANS_IDLE);
    cycle(4'b0001, 4'b0000, 1'b1, HTRANS_NONSEQ);
    check("park_default_alone", 32'(bus.hgrant), 32'h1);

    // Single request from master 2
    cycle(4'b0100, 4'b0000, 1'b1, HTRANS_IDLE);
    check("single_grant", 32'(bus.hgrant), 32'h4);
    cycle(4'b0100, 4'b0000, 1'b1, HTRANS_NONSEQ);
    check("single_hmaster", 32'(bus.hmaster), 32'h2);
    repeat (4) cycle(4'b0100, 4'b0000, 1'b1, HTRANS_SEQ);
    cycle(4'b0000, 4'b0000, 1'b1, HTRANS_IDLE);
    check("drop_park", 32'(bus.hgrant), 32'h1);

    // Round robin between masters 1 and 3
    cycle(4'b1010, 4'b0000, 1'b1, HTRANS_NONSEQ);
    check("rr_first", 32'(bus.hgrant), 32'h2);
    for (int i = 0; i < 15; i++)
      cycle(4'b1010, 4'b0000, 1'b1, (i % 4 == 0) ? HTRANS_NONSEQ : HTRANS_SEQ);
    check("rr_hold", 32'(bus.hgrant), 32'h2);
    cycle(4'b1010, 4'b0000, 1'b1, HTRANS_SEQ);
    check("rr_swap", 32'(bus.hgrant), 32'h8);

    // Stall five cycles inside master 3's tenure
    repeat (4) cycle(4'b1010, 4'b0000, 1'b1, HTRANS_SEQ);
    repeat (5) cycle(4'b1010, 4'b0000, 1'b0, HTRANS_SEQ);
    check("stall_frozen", 32'(bus.hgrant), 32'h8);
    repeat (11) cycle(4'b1010, 4'b0000, 1'b1, HTRANS_SEQ);
    check("stall_before_swap", 32'(bus.hgrant), 32'h8);
    cycle(4'b1010, 4'b0000, 1'b1, HTRANS_SEQ);
    check("stall_swap", 32'(bus.hgrant), 32'h2);

    // All requests drop together
    cycle(4'b0000, 4'b0000, 1'b1, HTRANS_IDLE);
    check("all_drop", 32'(bus.hgrant), 32'h1);

    // Locked burst by master 2 while master 0 waits
    cycle(4'b0101, 4'b0100, 1'b1, HTRANS_NONSEQ);
    check("lock_grant", 32'(bus.hgrant), 32'h4);
    for (int i = 0; i < 40; i++) begin
      cycle(4'b0101, 4'b0100, 1'b1, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ);
      check("lock_no_preempt", 32'(bus.hgrant), 32'h4);
      check("lock_hmastlock", 32'(bus.hmastlock), 32'h1);
    end
    cycle(4'b0101, 4'b0000, 1'b1, HTRANS_IDLE);
    check("lock_release", 32'(bus.hgrant), 32'h1);
    cycle(4'b0001, 4'b0000, 1'b1, HTRANS_IDLE);
    check("unlock_hmastlock", 32'(bus.hmastlock), 32'h0);
    check("unlock_hmaster", 32'(bus.hmaster), 32'h0);

    // Owner drops while another requests: direct handover, no park
    cycle(4'b1000, 4'b0000, 1'b1, HTRANS_IDLE);
    check("handover_no_park", 32'(bus.hgrant), 32'h8);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rq = 4'($urandom_range(0, 15));
      lk = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      rd = ($urandom_range(0, 4) != 0);
      tr = 2'($urandom_range(0, 3));
      cycle(rq, lk, rd, tr);
    end

    // Asynchronous reset in the middle of a cycle
    cycle(4'b0110, 4'b0000, 1'b1, HTRANS_NONSEQ);
    cycle(4'b0110, 4'b0000, 1'b1, HTRANS_SEQ);
    #3 hreset = 1'b1;
    #1;
    check("midrst_hgrant", 32'(bus.hgrant), 32'h1);
    check("midrst_hmaster", 32'(bus.hmaster), 32'h0);
    check("midrst_hmastlock", 32'(bus.hmastlock), 32'h0);
    model_reset();
    sb_q.delete();
    #2 hreset = 1'b0;
    repeat (3) cycle(4'b0000, 4'b0000, 1'b1, HTRANS_IDLE);
    check("post_reset_park", 32'(bus.hgrant), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
